// File: rtl/junction_pkg.sv
// Shared state encoding and default timing constants for the junction light sequencer.
package junction_pkg;

    typedef enum logic [3:0] {
        ST_SET      = 4'd0,
        ST_CLEAR_A  = 4'd1,
        ST_A_GREEN  = 4'd2,
        ST_A_YELLOW = 4'd3,
        ST_CLEAR_B  = 4'd4,
        ST_B_GREEN  = 4'd5,
        ST_B_YELLOW = 4'd6,
        ST_CLEAR_P  = 4'd7,
        ST_PED_WALK = 4'd8
    } state_e;

    localparam int TICK_DIV_DEF  = 10;
    localparam int GREEN_MS_DEF  = 5000;
    localparam int YELLOW_MS_DEF = 1000;
    localparam int CLEAR_MS_DEF  = 500;
    localparam int WALK_MS_DEF   = 3000;

    // Durations are counted by a 16-bit ms counter and compared against DUR-1.
    function automatic bit dur_ok(input int d);
        return (d >= 1) && (d <= 65535);
    endfunction

endpackage

// File: rtl/junction_sequencer_ms_tick_gen.sv
// 1 ms prescaler: counts enabled cycles and flags the last one of each tick period.
// Synchronous clear restarts the period; the clear wins over enable.
module ms_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic CLK,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/junction_sequencer.sv
// Junction light sequencer: timed set/change pulses for two vehicle groups and one pedestrian group.
// Pedestrian phase built only with JUNCTION_PED_PHASE_EN; otherwise change_p/ped_pending are held at 0.
module junction_sequencer
    import junction_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int GREEN_MS  = GREEN_MS_DEF,
    parameter int YELLOW_MS = YELLOW_MS_DEF,
    parameter int CLEAR_MS  = CLEAR_MS_DEF,
    parameter int WALK_MS   = WALK_MS_DEF
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       ped_req,
    output logic       set_all,
    output logic       change_a,
    output logic       change_b,
    output logic       change_p,
    output logic [3:0] phase,
    output logic       ped_pending
);

    if (TICK_DIV < 1 || !dur_ok(GREEN_MS) || !dur_ok(YELLOW_MS) ||
        !dur_ok(CLEAR_MS) || !dur_ok(WALK_MS)) begin : g_bad_param
        $error("junction_sequencer: TICK_DIV must be >= 1 and every duration in 1..65535");
    end

    state_e      state_q, state_d;
    logic [15:0] phase_ms_q, phase_ms_d;
    logic        set_all_q, set_all_d;
    logic        change_a_q, change_a_d;
    logic        change_b_q, change_b_d;
    logic        change_p_q, change_p_d;
    logic        ped_pending_q, ped_pending_d;
    logic        tick;
    logic        trans;
    logic        expire;
    logic [15:0] dur;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK    (CLK),
        .reset  (reset),
        .en_i   (en),
        .clr_i  (trans),
        .tick_o (tick)
    );

    always_comb begin
        dur = 16'(CLEAR_MS);
        case (state_q)
            ST_A_GREEN,  ST_B_GREEN:  dur = 16'(GREEN_MS);
            ST_A_YELLOW, ST_B_YELLOW: dur = 16'(YELLOW_MS);
            ST_PED_WALK:              dur = 16'(WALK_MS);
            default:                  dur = 16'(CLEAR_MS);
        endcase
    end

    // tick already carries en, so a frozen sequencer can never expire.
    assign expire = tick && (phase_ms_q == dur - 16'd1);

    always_comb begin
        state_d    = state_q;
        trans      = 1'b0;
        set_all_d  = 1'b0;
        change_a_d = 1'b0;
        change_b_d = 1'b0;
        change_p_d = 1'b0;
        case (state_q)
            ST_SET: if (en) begin
                trans = 1'b1; set_all_d = 1'b1; state_d = ST_CLEAR_A;
            end
            ST_CLEAR_A: if (expire) begin
                trans = 1'b1; change_a_d = 1'b1; state_d = ST_A_GREEN;
            end
            ST_A_GREEN: if (expire) begin
                trans = 1'b1; change_a_d = 1'b1; state_d = ST_A_YELLOW;
            end
            ST_A_YELLOW: if (expire) begin
                trans = 1'b1; change_a_d = 1'b1; state_d = ST_CLEAR_B;
            end
            ST_CLEAR_B: if (expire) begin
                trans = 1'b1; change_b_d = 1'b1; state_d = ST_B_GREEN;
            end
            ST_B_GREEN: if (expire) begin
                trans = 1'b1; change_b_d = 1'b1; state_d = ST_B_YELLOW;
            end
            ST_B_YELLOW: if (expire) begin
                trans = 1'b1; change_b_d = 1'b1; state_d = ST_CLEAR_P;
            end
            ST_CLEAR_P: if (expire) begin
                trans = 1'b1;
                if (ped_pending_q) begin
                    change_p_d = 1'b1; state_d = ST_PED_WALK;
                end else begin
                    change_a_d = 1'b1; state_d = ST_A_GREEN;
                end
            end
            ST_PED_WALK: if (expire) begin
                trans = 1'b1; change_p_d = 1'b1; state_d = ST_CLEAR_A;
            end
            default: begin
                trans = 1'b1; state_d = ST_SET;
            end
        endcase
    end

    always_comb begin
        phase_ms_d = phase_ms_q;
        if (trans) begin
            phase_ms_d = '0;
        end else if (tick) begin
            phase_ms_d = phase_ms_q + 16'd1;
        end
    end

`ifdef JUNCTION_PED_PHASE_EN
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (trans && state_d == ST_PED_WALK) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && state_q != ST_PED_WALK) begin
            ped_pending_d = 1'b1;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pending_d  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_SET;
            phase_ms_q    <= '0;
            set_all_q     <= 1'b0;
            change_a_q    <= 1'b0;
            change_b_q    <= 1'b0;
            change_p_q    <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_ms_q    <= phase_ms_d;
            set_all_q     <= set_all_d;
            change_a_q    <= change_a_d;
            change_b_q    <= change_b_d;
            change_p_q    <= change_p_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    assign set_all     = set_all_q;
    assign change_a    = change_a_q;
    assign change_b    = change_b_q;
    assign change_p    = change_p_q;
    assign phase       = state_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_junction_sequencer.sv
// Scoreboard bench: expected pulses (gap since previous pulse, pulse vector, new phase) are queued by the stimulus.
module tb_junction_sequencer;

    localparam int TD = 10;
`ifdef JUNCTION_PED_PHASE_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam logic [3:0] P_SET = 4'b1000;
    localparam logic [3:0] P_A   = 4'b0100;
    localparam logic [3:0] P_B   = 4'b0010;
    localparam logic [3:0] P_P   = 4'b0001;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       ped_req = 1'b0;
    logic       set_all, change_a, change_b, change_p, ped_pending;
    logic [3:0] phase;

    junction_sequencer #(
        .TICK_DIV (TD),
        .GREEN_MS (4),
        .YELLOW_MS(2),
        .CLEAR_MS (1),
        .WALK_MS  (3)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .en         (en),
        .ped_req    (ped_req),
        .set_all    (set_all),
        .change_a   (change_a),
        .change_b   (change_b),
        .change_p   (change_p),
        .phase      (phase),
        .ped_pending(ped_pending)
    );

    always #50 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         gap;
        logic [3:0] pulses;
        logic [3:0] ph;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_cyc = 0;

    task automatic push(input int gap, input logic [3:0] p, input logic [3:0] ph);
        exp_t e;
        e.gap = gap; e.pulses = p; e.ph = ph;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        logic [3:0] pv;
        exp_t       e;
        pv = {set_all, change_a, change_b, change_p};
        if (reset) begin
            last_cyc = cyc;
        end else if (pv != 4'b0000) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got pulses=%b phase=%0d at cycle %0d, required no pulse",
                         pv, phase, cyc);
            end else begin
                e = q.pop_front();
                if (pv !== e.pulses || phase !== e.ph || (cyc - last_cyc) != e.gap) begin
                    n_fail++;
                    $display("FAIL pulse: got pulses=%b phase=%0d gap=%0d, required pulses=%b phase=%0d gap=%0d",
                             pv, phase, cyc - last_cyc, e.pulses, e.ph, e.gap);
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic wait_phase(input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (phase == 4'(p)) return;
            step(1);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_phase: got phase %0d, required %0d within %0d cycles", phase, p, budget);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_set_all"},  int'(set_all),     0);
        check({tag, "_change_a"}, int'(change_a),    0);
        check({tag, "_change_b"}, int'(change_b),    0);
        check({tag, "_change_p"}, int'(change_p),    0);
        check({tag, "_phase"},    int'(phase),       0);
        check({tag, "_ped"},      int'(ped_pending), 0);
    endtask

    task automatic push_round_from_a_green();
        push(40, P_A, 3); push(20, P_A, 4);
        push(10, P_B, 5); push(40, P_B, 6); push(20, P_B, 7);
        if (PED) begin
            push(10, P_P, 8); push(30, P_P, 1); push(10, P_A, 2);
        end else begin
            push(10, P_A, 2);
        end
    endtask

    initial begin
        step(3);
        check_reset_state("rst");

        // Release: set_all one edge later, then CLEAR_A, then an undisturbed round.
        push(1, P_SET, 1); push(10, P_A, 2);
        push(40, P_A, 3); push(20, P_A, 4);
        push(10, P_B, 5); push(40, P_B, 6); push(20, P_B, 7);
        push(10, P_A, 2);
        reset = 1'b0;
        en    = 1'b1;
        wait_phase(7, 200);
        wait_phase(2, 50);

        // One-cycle ped_req in B_GREEN.
        push_round_from_a_green();
        wait_phase(5, 100);
        step(3);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        check("ped_latched", int'(ped_pending), int'(PED));
        wait_phase(PED ? 8 : 2, 200);
        check("ped_cleared", int'(ped_pending), 0);
        wait_phase(2, 100);

        // 25-cycle freeze inside A_GREEN stretches the gap from 40 to 65.
        push(65, P_A, 3); push(20, P_A, 4);
        push(10, P_B, 5); push(40, P_B, 6);
        step(15);
        en = 1'b0;
        step(25);
        check("frozen_phase", int'(phase), 2);
        en = 1'b1;

        // Reset in B_YELLOW.
        wait_phase(6, 200);
        step(5);
        reset = 1'b1;
        step(1);
        check_reset_state("midrst");
        push(1, P_SET, 1); push(10, P_A, 2);
        reset = 1'b0;
        wait_phase(2, 50);

        // ped_req held high for a whole round.
        push_round_from_a_green();
        ped_req = 1'b1;
        for (int i = 0; i < 400 && q.size() > 0; i++) step(1);
        check("queue_drained", q.size(), 0);
        check("ped_final", int'(ped_pending), int'(PED));
        ped_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
